fetch_decode_unit: RTL
======================

Name: fetch_decode_unit

Overview:
- Multi-cycle fetch/decode/control stage sitting directly upstream of the add-sub datapath.
- Fetches 32-bit RV64I instructions from an external instruction memory over a req/valid handshake and holds each one in an instruction register (IR).
- Drives the datapath register selectors, the 12-bit immediate and all control strobes for ld, sd, add, sub and addi.
- Each instruction retires in one EXEC cycle.

Parameters:
- PC_WIDTH, 64, width of program counter and imem_addr.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high in FETCH until imem_valid.
- imem_addr  output  PC_WIDTH  current PC; stable while imem_req high.
- imem_valid  input  1  imem_rdata valid this cycle; ignored outside FETCH.
- imem_rdata  input  32  instruction word.
- rs1  output  5  IR[19:15].
- rs2  output  5  IR[24:20].
- rd  output  5  IR[11:7].
- immediate  output  12  I-type: IR[31:20]; S-type: {IR[31:25],IR[11:7]}; else 0.
- sub  output  1  1 only for R-type with IR[30]=1.
- WE_RF  output  1  register-file write strobe.
- WE_MEM  output  1  data-memory write strobe.
- RF_din_sel  output  1  1 = ALU result, 0 = memory data.
- ULA_din2_sel  output  1  1 = immediate, 0 = rs2 data.
- instr_retired  output  1  one-cycle pulse in EXEC.
- illegal  output  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset: CLK and RST as decided; reset is synchronous and active-high. On any rising edge with RST=1:
  - state <= RESET_S, PC <= RESET_PC, IR <= 0.
  - While in RESET_S all outputs are 0, except imem_addr=RESET_PC.
  - Reset mid-FETCH drops imem_req. Reset mid-EXEC cancels the write: WE_* are low from the next cycle and PC is not incremented.
- States and transitions:
  - RESET_S -> FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=PC. When imem_valid=1: IR <= imem_rdata, go to DECODE. Otherwise stay in FETCH.
  - DECODE: one cycle. Field, immediate and mux-select outputs become valid. All strobes stay 0.
  - EXEC: one cycle. Write strobes per the decode list below. instr_retired=1. PC <= PC+4, go to FETCH.
- Latency: minimum 3 cycles per instruction (when imem_valid is high in the first FETCH cycle); each imem wait cycle adds one.
- Field/select outputs are combinational from IR. They stay stable through DECODE and EXEC and change only at the IR capture edge.
- Decode (opcode IR[6:0]; funct3 must be as listed, otherwise the instruction is illegal):
  - ld: 0000011, f3=011. ULA_din2_sel=1, RF_din_sel=0, WE_RF=1 in EXEC.
  - sd: 0100011, f3=011. ULA_din2_sel=1, WE_MEM=1 in EXEC.
  - addi: 0010011, f3=000. ULA_din2_sel=1, RF_din_sel=1, WE_RF=1.
  - add/sub: 0110011, f3=000, IR[31]=0, IR[29:25]=0. ULA_din2_sel=0, RF_din_sel=1, sub=IR[30], WE_RF=1.
- rd==0: WE_RF is suppressed. The instruction still retires and PC still advances.
- PC arithmetic is modulo 2^PC_WIDTH: PC = all-ones minus 3 wraps to 0.
- Illegal/unsupported instruction without the feature: treated as NOP. No strobes, retires, PC+4.

Optional Feature:
- Macro FDU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal instruction enters HALT from DECODE and sets illegal=1, held until reset.
  - In HALT: no imem_req, no strobes, no instr_retired, PC frozen at the faulting address.
- Undefined: illegal tied to 0; illegal instructions execute as NOP as above.

Test Plan:
- Reset then fetch, imem_valid on the first FETCH cycle:
  - imem_addr=0, imem_req high one cycle after RST falls.
  - instr_retired two cycles after IR capture.
  - Next imem_addr=4.
- addi x5,x1,-1 (0xFFF08293):
  - DECODE: rs1=1, rd=5, immediate=0xFFF, ULA_din2_sel=1, RF_din_sel=1.
  - EXEC: WE_RF=1, WE_MEM=0.
- sub x3,x1,x2 (0x402081B3): sub=1, ULA_din2_sel=0, WE_RF one cycle. Then add x3,x1,x2 (0x002081B3): sub=0.
- sd x2,8(x1) (0x0020B423): immediate=0x008, rs2=2, WE_MEM=1 for exactly one cycle, WE_RF=0. Then ld x4,8(x1) (0x0080B203): RF_din_sel=0, WE_RF=1.
- imem_valid delayed 3 cycles: imem_req and imem_addr held stable for 4 cycles, exactly one IR capture. Separately, addi x0,x0,1 gives WE_RF=0 but instr_retired=1.
- Illegal word 0x00000000:
  - Without macro: NOP, PC advances to +4.
  - With FDU_ILLEGAL_TRAP_EN: illegal=1, imem_req stays 0, PC unchanged until RST, then restart at RESET_PC.

Source files
------------

// File: rtl/fetch_decode_unit_if.sv
// fetch_decode_unit_if: instruction-memory fetch bus.
//   imem_req   - fetch request, held until imem_valid
//   imem_addr  - fetch address (current PC)
//   imem_valid - imem_rdata carries the requested word this cycle
//   imem_rdata - 32-bit instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_decode_unit_if #(
  parameter int unsigned PC_WIDTH = 64
);

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_valid;
  logic [31:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: multi-cycle fetch/decode/control stage for the add-sub
// datapath. Fetches one RV64I word per instruction into IR, decodes ld, sd,
// addi, add and sub, and drives register selectors, immediate and strobes.
// Sequence per instruction: FETCH (1+ cycles) -> DECODE -> EXEC.
//
// Ports:
//   CLK, RST      - clock, synchronous active-high reset
//   imem          - fetch bus (master side)
//   rs1, rs2, rd  - register selectors from IR
//   immediate     - 12-bit I/S-type immediate, 0 for other formats
//   sub           - subtract select for add/sub
//   WE_RF, WE_MEM - register-file / data-memory write strobes (EXEC only)
//   RF_din_sel    - 1 = ALU result, 0 = memory data
//   ULA_din2_sel  - 1 = immediate, 0 = rs2 data
//   instr_retired - one-cycle pulse in EXEC
//   illegal       - sticky illegal-instruction flag
//
// Build option: define FDU_ILLEGAL_TRAP_EN to halt on an illegal
// instruction (sticky illegal flag, no further fetches until reset).
// Without it illegal instructions execute as NOPs and illegal stays 0.
module fetch_decode_unit #(
  parameter int unsigned         PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  fetch_decode_unit_if.master  imem,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [11:0]          immediate,
  output logic                 sub,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic                 RF_din_sel,
  output logic                 ULA_din2_sel,
  output logic                 instr_retired,
  output logic                 illegal
);

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [2:0] F3_DWORD  = 3'b011;
  localparam logic [2:0] F3_ADD    = 3'b000;

  typedef enum logic [2:0] {
    RESET_S,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [INSTR_W-1:0]   ir_q;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 is_ld;
  logic                 is_sd;
  logic                 is_addi;
  logic                 is_addsub;

  // State, PC and instruction register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RESET_S;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem.imem_valid) begin
        ir_q <= imem.imem_rdata;
      end
      // Modulo 2^PC_WIDTH by construction of the adder width
      if (state_q == EXEC) begin
        pc_q <= pc_q + PC_WIDTH'(4);
      end
    end
  end

  // Instruction classification from IR
  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_ld     = (opcode == OP_LOAD)  && (funct3 == F3_DWORD);
  assign is_sd     = (opcode == OP_STORE) && (funct3 == F3_DWORD);
  assign is_addi   = (opcode == OP_IMM)   && (funct3 == F3_ADD);
  // funct7 must be 0000000 (add) or 0100000 (sub); bit 30 is the only free bit
  assign is_addsub = (opcode == OP_REG)   && (funct3 == F3_ADD) &&
                     !ir_q[31] && (ir_q[29:25] == 5'd0);

  // Field and mux-select outputs track IR only
  assign rs1          = ir_q[19:15];
  assign rs2          = ir_q[24:20];
  assign rd           = ir_q[11:7];
  assign sub          = is_addsub && ir_q[30];
  assign ULA_din2_sel = is_ld || is_sd || is_addi;
  assign RF_din_sel   = is_addi || is_addsub;

  // Immediate format follows the opcode
  always_comb begin
    immediate = 12'd0;
    case (opcode)
      OP_LOAD, OP_IMM: immediate = ir_q[31:20];
      OP_STORE:        immediate = {ir_q[31:25], ir_q[11:7]};
      default:         immediate = 12'd0;
    endcase
  end

  assign imem.imem_addr = pc_q;

`ifdef FDU_ILLEGAL_TRAP_EN
  logic legal;
  logic illegal_q;

  assign legal = is_ld || is_sd || is_addi || is_addsub;

  // Sticky trap flag, set when DECODE sees an unsupported word
  always_ff @(posedge CLK) begin
    if (RST) begin
      illegal_q <= 1'b0;
    end else if (state_q == DECODE && !legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Next state and per-state strobes
  always_comb begin
    state_d        = state_q;
    imem.imem_req  = 1'b0;
    WE_RF          = 1'b0;
    WE_MEM         = 1'b0;
    instr_retired  = 1'b0;

    case (state_q)
      RESET_S: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_valid) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
`ifdef FDU_ILLEGAL_TRAP_EN
        state_d = legal ? EXEC : HALT;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        // x0 is hardwired to zero, so its write is dropped
        WE_RF         = (is_ld || is_addi || is_addsub) && (rd != 5'd0);
        WE_MEM        = is_sd;
        instr_retired = 1'b1;
        state_d       = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RESET_S;
      end
    endcase
  end

endmodule
